// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-addressed on-chip memory, with
// programmable wait states and the two-cycle ERROR response on illegal accesses.
module ahb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic [IDX_W+1:0]      addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic [IDX_W-1:0]      word_idx;
  logic                  accept_ready;
  logic                  sample;
  logic                  illegal;
  logic [3:0]            lane_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  unused_ok;

  // Burst type is informational (the master sequences addresses); HTRANS[0]
  // only separates NONSEQ from SEQ, which are handled identically here.
  assign unused_ok = ^{HBURST, HTRANS[0]};

  // A new address is accepted only in states whose data phase completes now.
  assign accept_ready = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign sample       = HSEL && HREADY && HTRANS[1] && accept_ready;

  assign illegal = (HSIZE > SIZE_WORD)
                || ((HSIZE == SIZE_HALF) && HADDR[0])
                || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00))
                || (HADDR[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == '0) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        HRESP = (state == ST_ERR2);
        if (sample) begin
          if (illegal) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_INIT;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (sample) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  assign word_idx = addr_q[IDX_W+1:2];

  // Little-endian lane selection; only legal sizes ever reach the data phase.
  always_comb begin
    lane_en = '0;
    case (size_q)
      2'b00:   lane_en[addr_q[1:0]] = 1'b1;
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = '1;
    endcase
  end

  assign mem_we = (state == ST_DATA) && write_q;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Combinational read so a write committed on the previous edge is visible.
  assign HRDATA = ((state == ST_DATA) && !write_q) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a pipelined AHB-Lite master drives two instances
// (zero and three wait states) and a scoreboard checks every data phase.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic        use_ws;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        ro0, rs0, ro1, rs1;
  logic [31:0] rd0, rd1;
  logic        obs_ready, obs_resp;
  logic [31:0] obs_rdata;

  always #5 clk = ~clk;

  ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~use_ws), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(ro0),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & use_ws), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(ro1),
    .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
  );

  assign obs_ready = use_ws ? ro1 : ro0;
  assign obs_resp  = use_ws ? rs1 : rs0;
  assign obs_rdata = use_ws ? rd1 : rd0;

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic [7:0]  waits;
    logic        lowresp;
  } obs_t;

  xfer_t       xq[$];
  obs_t        exp_q[$];
  obs_t        got_q[$];
  logic [31:0] model [2][256];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic illegal_f(input xfer_t x);
    return (x.size > 3'b010) || ((x.size == 3'b001) && x.addr[0]) ||
           ((x.size == 3'b010) && (x.addr[1:0] != 2'b00)) || (x.addr >= 32'h400);
  endfunction

  task automatic add(input logic [1:0] trans, input logic write, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    x.trans = trans; x.write = write; x.size = size; x.addr = addr; x.wdata = wdata;
    xq.push_back(x);
  endtask

  // Runs the queued transfers as a pipelined master; pushes the expected
  // data-phase result when each address phase is driven, and records what
  // the DUT actually returned when that data phase completes.
  task automatic run();
    xfer_t       cur, prev;
    obs_t        e, g;
    int          w, n, ws;
    logic [3:0]  be;
    logic [7:0]  idx;
    logic [31:0] tmp;
    n    = xq.size();
    ws   = use_ws ? 3 : 0;
    prev = '0;
    for (int i = 0; i <= n; i++) begin
      cur    = (i < n) ? xq[i] : '0;
      hsel   = 1'b1;
      haddr  = cur.addr;
      htrans = cur.trans;
      hwrite = cur.write;
      hsize  = cur.size;
      hburst = 3'b011;
      hwdata = prev.wdata;
      if (i < n) begin
        e = '0;
        if (cur.trans[1]) begin
          if (illegal_f(cur)) begin
            e.resp = 1'b1; e.waits = 8'd1; e.lowresp = 1'b1;
          end else begin
            e.waits = 8'(ws);
            idx = cur.addr[9:2];
            tmp = model[use_ws][idx];
            if (cur.write) begin
              be = (cur.size == 3'b000) ? (4'b0001 << cur.addr[1:0]) :
                   (cur.size == 3'b001) ? (cur.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
              for (int b = 0; b < 4; b++) if (be[b]) tmp[8*b +: 8] = cur.wdata[8*b +: 8];
              model[use_ws][idx] = tmp;
            end else begin
              e.rdata = tmp;
            end
          end
        end
        exp_q.push_back(e);
      end
      w = 0;
      g = '0;
      forever begin
        @(negedge clk);
        if (obs_ready) break;
        w++;
        g.lowresp = g.lowresp | obs_resp;
        if (w >= 40) break;
      end
      if (i > 0) begin
        g.rdata = obs_rdata; g.resp = obs_resp; g.waits = 8'(w);
        got_q.push_back(g);
      end
      @(posedge clk); #1;
      prev = cur;
    end
    xq.delete();
    htrans = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hsel = 1'b0; use_ws = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000; hwdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ro0 !== 1'b1) begin n_bad++; $display("FAIL reset dut0 hreadyout: got %b want 1", ro0); end
    n_cmp++; if (rs0 !== 1'b0) begin n_bad++; $display("FAIL reset dut0 hresp: got %b want 0", rs0); end
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL reset dut0 hrdata: got %h want 0", rd0); end
    n_cmp++; if (ro1 !== 1'b1) begin n_bad++; $display("FAIL reset dut1 hreadyout: got %b want 1", ro1); end
    n_cmp++; if (rs1 !== 1'b0) begin n_bad++; $display("FAIL reset dut1 hresp: got %b want 0", rs1); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset dut1 hrdata: got %h want 0", rd1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b0;
    add(2'b10, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    add(2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
    n_cmp++; if (g.rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b raw hrdata: got %h want deadbeef", g.rdata); end
  endtask

  task automatic test_byte_lanes();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b0;
    add(2'b10, 1'b1, 3'b010, 32'h20, 32'h11223344);
    add(2'b10, 1'b1, 3'b000, 32'h21, 32'h0000AA00);
    add(2'b10, 1'b1, 3'b001, 32'h22, 32'h55660000);
    add(2'b10, 1'b0, 3'b010, 32'h20, 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL lanes[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
    n_cmp++; if (g.rdata !== 32'h5566AA44) begin n_bad++; $display("FAIL lanes raw hrdata: got %h want 5566aa44", g.rdata); end
  endtask

  task automatic test_wait_burst();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b1;
    for (int a = 0; a < 4; a++) add(2'b10, 1'b1, 3'b010, 32'h40 + 32'(4*a), 32'hC0DE0000 + 32'(a));
    add(2'b10, 1'b0, 3'b010, 32'h40, 32'h0);
    for (int a = 1; a < 4; a++) add(2'b11, 1'b0, 3'b010, 32'h40 + 32'(4*a), 32'h0);
    add(2'b10, 1'b0, 3'b010, 32'h41, 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL wait[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
    use_ws = 1'b0;
  endtask

  task automatic test_errors();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b0;
    add(2'b10, 1'b1, 3'b010, 32'h00, 32'h01020304);
    add(2'b10, 1'b1, 3'b010, 32'h04, 32'h05060708);
    add(2'b10, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 3'b011, 32'h04, 32'hFFFFFFFF);
    add(2'b10, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF);
    add(2'b10, 1'b0, 3'b010, 32'h400, 32'h0);
    add(2'b10, 1'b1, 3'b001, 32'h05, 32'hFFFFFFFF);
    add(2'b10, 1'b0, 3'b010, 32'h00, 32'h0);
    add(2'b10, 1'b0, 3'b010, 32'h04, 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL err[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
  endtask

  task automatic test_busy_burst();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b0;
    add(2'b10, 1'b1, 3'b010, 32'h60, 32'hA0A0A0A0);
    add(2'b11, 1'b1, 3'b010, 32'h64, 32'hA1A1A1A1);
    add(2'b01, 1'b1, 3'b010, 32'h68, 32'hBAD0BAD0);
    add(2'b11, 1'b1, 3'b010, 32'h68, 32'hA2A2A2A2);
    add(2'b11, 1'b1, 3'b010, 32'h6C, 32'hA3A3A3A3);
    add(2'b10, 1'b0, 3'b010, 32'h60, 32'h0);
    for (int a = 1; a < 4; a++) add(2'b11, 1'b0, 3'b010, 32'h60 + 32'(4*a), 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL busy[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    int k = 0;
    use_ws = 1'b1;
    add(2'b10, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D);
    run();
    hsel = 1'b1; haddr = 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h99999999;
    @(negedge clk);
    n_cmp++; if (ro1 !== 1'b0) begin n_bad++; $display("FAIL rstmid wait hreadyout: got %b want 0", ro1); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ro1 !== 1'b1) begin n_bad++; $display("FAIL rstmid hreadyout: got %b want 1", ro1); end
    n_cmp++; if (rs1 !== 1'b0) begin n_bad++; $display("FAIL rstmid hresp: got %b want 0", rs1); end
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL rstmid hrdata: got %h want 0", rd1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add(2'b10, 1'b0, 3'b010, 32'h80, 32'h0);
    run();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); k++;
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL rstmid[%0d]: got rdata=%h resp=%b waits=%0d lowresp=%b want rdata=%h resp=%b waits=%0d lowresp=%b",
                 k, g.rdata, g.resp, g.waits, g.lowresp, e.rdata, e.resp, e.waits, e.lowresp);
      end
    end
    n_cmp++; if (g.rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rstmid raw hrdata: got %h want cafef00d", g.rdata); end
    use_ws = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_burst();
    test_errors();
    test_busy_burst();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
